// File: rtl/hazard_scoreboard_pkg.sv
// Shared scoreboard dimensions and issue-control state encoding, reused by
// fetch/decode so everyone agrees on what RUN/BR_WAIT/HALT mean.
package hazard_scoreboard_pkg;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    HALT    = 2'd2
  } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// One pending-write counter: saturating up/down with underflow/overflow flags.
// An erroneous update leaves the count unchanged.
module hazard_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow,
  output logic             o_overflow
);

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  assign o_cnt       = r_cnt;
  assign o_underflow = i_en && i_dec && (r_cnt == '0);
  assign o_overflow  = i_en && i_inc && !i_dec && (r_cnt == CMAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en && !o_underflow && !o_overflow) begin
      // Simultaneous inc and dec cancel out.
      if (i_inc && !i_dec)
        r_cnt <= r_cnt + 1'b1;
      else if (i_dec && !i_inc)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue scoreboard: per-register and CC pending-write tracking,
// writeback bypass folded into the grant, and branch/halt fetch hold.
module hazard_scoreboard #(
  parameter int NUM_REGS = hazard_scoreboard_pkg::NUM_REGS,
  parameter int IDX_W    = hazard_scoreboard_pkg::IDX_W,
  parameter int CNT_W    = hazard_scoreboard_pkg::CNT_W
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET,
  input  logic                I_LOCK,
  input  logic                I_IssueValid,
  input  logic                I_Src1Used,
  input  logic                I_Src2Used,
  input  logic [IDX_W-1:0]    I_Src1Idx,
  input  logic [IDX_W-1:0]    I_Src2Idx,
  input  logic                I_DestUsed,
  input  logic [IDX_W-1:0]    I_DestIdx,
  input  logic                I_SetsCC,
  input  logic                I_UsesCC,
  input  logic                I_IsBranch,
  input  logic                I_WriteBackEnable,
  input  logic [IDX_W-1:0]    I_WriteBackRegIdx,
  input  logic                I_WriteBackSetsCC,
  input  logic                I_BranchResolved,
  output logic                O_IssueGrant,
  output logic                O_DepStallSignal,
  output logic                O_BranchStallSignal,
  output logic [NUM_REGS-1:0] O_PendingMask,
  output logic                O_Error
);

  import hazard_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  sb_state_e        r_state, w_state_nxt;
  logic             r_error;
  logic [CNT_W-1:0] w_cnt [NUM_REGS];
  logic [CNT_W-1:0] w_ccnt;
  logic [NUM_REGS:0] w_underflow, w_overflow;
  logic [NUM_REGS-1:0] w_inc, w_dec;
  logic w_src1_rdy, w_src2_rdy, w_cc_rdy, w_dest_ok;
  logic w_issue_try, w_grant, w_err;

  // A producer retiring this very cycle counts as already written.
  function automatic logic src_ready(input logic used, input logic [CNT_W-1:0] cnt,
                                     input logic bypass);
    return !used || (cnt == '0) || ((cnt == CNT_W'(1)) && bypass);
  endfunction

  assign w_src1_rdy = src_ready(I_Src1Used, w_cnt[I_Src1Idx],
                                I_WriteBackEnable && (I_WriteBackRegIdx == I_Src1Idx));
  assign w_src2_rdy = src_ready(I_Src2Used, w_cnt[I_Src2Idx],
                                I_WriteBackEnable && (I_WriteBackRegIdx == I_Src2Idx));
  assign w_cc_rdy   = src_ready(I_UsesCC, w_ccnt, I_WriteBackEnable && I_WriteBackSetsCC);
  assign w_dest_ok  = !I_DestUsed || (w_cnt[I_DestIdx] != CMAX);

  assign w_issue_try      = I_LOCK && I_IssueValid && (r_state == RUN);
  assign O_DepStallSignal = w_issue_try && !(w_src1_rdy && w_src2_rdy && w_cc_rdy && w_dest_ok);
  assign w_grant          = w_issue_try && !O_DepStallSignal;
  assign O_IssueGrant     = w_grant;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign w_inc[gi] = w_grant && I_DestUsed && (I_DestIdx == IDX_W'(gi));
    assign w_dec[gi] = I_WriteBackEnable && (I_WriteBackRegIdx == IDX_W'(gi));
    assign O_PendingMask[gi] = (w_cnt[gi] != '0);

    hazard_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk       (I_CLOCK),
      .i_rst       (I_RESET),
      .i_en        (I_LOCK),
      .i_inc       (w_inc[gi]),
      .i_dec       (w_dec[gi]),
      .o_cnt       (w_cnt[gi]),
      .o_underflow (w_underflow[gi]),
      .o_overflow  (w_overflow[gi])
    );
  end

  hazard_counter #(.CNT_W(CNT_W)) u_cc_cnt (
    .i_clk       (I_CLOCK),
    .i_rst       (I_RESET),
    .i_en        (I_LOCK),
    .i_inc       (w_grant && I_SetsCC),
    .i_dec       (I_WriteBackEnable && I_WriteBackSetsCC),
    .o_cnt       (w_ccnt),
    .o_underflow (w_underflow[NUM_REGS]),
    .o_overflow  (w_overflow[NUM_REGS])
  );

  assign w_err = (|w_underflow) || (|w_overflow);

  always_comb begin
    w_state_nxt = r_state;
    if (I_LOCK) begin
      if (w_err) begin
        w_state_nxt = HALT;
      end else begin
        case (r_state)
          RUN:     if (w_grant && I_IsBranch) w_state_nxt = BR_WAIT;
          BR_WAIT: if (I_BranchResolved) w_state_nxt = RUN;
          default: w_state_nxt = HALT;
        endcase
      end
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      r_state <= RUN;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (I_LOCK && w_err)
        r_error <= 1'b1;
    end
  end

  assign O_BranchStallSignal = (r_state != RUN);
  assign O_Error             = r_error;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each cycle's expected outputs are
// queued by the driver and checked mid-cycle by an independent monitor.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, lock, vld, s1u, s2u, du, setcc, usecc, isbr;
  logic [3:0]  s1, s2, d, wbidx;
  logic        wben, wbcc, resolved;
  logic        grant, dstall, bstall, err;
  logic [15:0] mask;

  typedef struct packed {
    int          id;
    logic        g;
    logic        ds;
    logic        bs;
    logic [15:0] mask;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .I_CLOCK             (clk),
    .I_RESET             (rst),
    .I_LOCK              (lock),
    .I_IssueValid        (vld),
    .I_Src1Used          (s1u),
    .I_Src2Used          (s2u),
    .I_Src1Idx           (s1),
    .I_Src2Idx           (s2),
    .I_DestUsed          (du),
    .I_DestIdx           (d),
    .I_SetsCC            (setcc),
    .I_UsesCC            (usecc),
    .I_IsBranch          (isbr),
    .I_WriteBackEnable   (wben),
    .I_WriteBackRegIdx   (wbidx),
    .I_WriteBackSetsCC   (wbcc),
    .I_BranchResolved    (resolved),
    .O_IssueGrant        (grant),
    .O_DepStallSignal    (dstall),
    .O_BranchStallSignal (bstall),
    .O_PendingMask       (mask),
    .O_Error             (err)
  );

  task automatic chk(input int id, input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL step %0d %s got %h want %h", id, nm, act, exp_v);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, inputs change just after posedge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.id, "grant",    {15'd0, grant},  {15'd0, e.g});
      chk(e.id, "depstall", {15'd0, dstall}, {15'd0, e.ds});
      chk(e.id, "brstall",  {15'd0, bstall}, {15'd0, e.bs});
      chk(e.id, "mask",     mask,            e.mask);
      chk(e.id, "error",    {15'd0, err},    {15'd0, e.err});
    end
  end

  task automatic idle();
    rst = 1'b0; lock = 1'b1; vld = 1'b0; s1u = 1'b0; s2u = 1'b0; du = 1'b0;
    setcc = 1'b0; usecc = 1'b0; isbr = 1'b0; s1 = '0; s2 = '0; d = '0;
    wben = 1'b0; wbidx = '0; wbcc = 1'b0; resolved = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic op(input logic a1u, input logic [3:0] a1, input logic a2u, input logic [3:0] a2,
                    input logic adu, input logic [3:0] ad, input logic asc, input logic auc,
                    input logic abr);
    vld = 1'b1; s1u = a1u; s1 = a1; s2u = a2u; s2 = a2; du = adu; d = ad;
    setcc = asc; usecc = auc; isbr = abr;
  endtask

  task automatic wb(input logic [3:0] idx, input logic cc);
    wben = 1'b1; wbidx = idx; wbcc = cc;
  endtask

  task automatic expect_o(input logic g, input logic ds, input logic bs, input logic [15:0] m,
                          input logic e);
    exp_t x;
    x.id = step_id; x.g = g; x.ds = ds; x.bs = bs; x.mask = m; x.err = e;
    q.push_back(x);
    step_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle();
    expect_o(0, 0, 0, 16'h0000, 0);                                    // reset state
    nxt(); op(1, 2, 1, 3, 1, 1, 0, 0, 0); expect_o(1, 0, 0, 16'h0000, 0); // ADD R1<-R2,R3
    nxt(); op(1, 1, 1, 1, 1, 5, 0, 0, 0); expect_o(0, 1, 0, 16'h0002, 0); // reader of R1 stalls
    nxt(); op(1, 1, 1, 1, 1, 5, 0, 0, 0); wb(1, 0);
    expect_o(1, 0, 0, 16'h0002, 0);                                    // bypass on writeback
    nxt(); wb(5, 0);                      expect_o(0, 0, 0, 16'h0020, 0);
    nxt(); op(1, 2, 0, 0, 1, 6, 1, 0, 0); expect_o(1, 0, 0, 16'h0000, 0); // CC setter
    nxt(); op(0, 0, 0, 0, 0, 0, 0, 1, 1); expect_o(0, 1, 0, 16'h0040, 0); // BRZ stalls on CC
    nxt(); op(0, 0, 0, 0, 0, 0, 0, 1, 1); wb(6, 1);
    expect_o(1, 0, 0, 16'h0040, 0);                                    // BRZ via CC bypass
    nxt(); resolved = 1'b1;               expect_o(0, 0, 1, 16'h0000, 0);
    nxt(); op(0, 0, 0, 0, 0, 0, 0, 0, 1); expect_o(1, 0, 0, 16'h0000, 0); // JMP
    nxt(); op(1, 3, 0, 0, 1, 2, 0, 0, 0); expect_o(0, 0, 1, 16'h0000, 0);
    nxt(); op(1, 3, 0, 0, 1, 2, 0, 0, 0); expect_o(0, 0, 1, 16'h0000, 0);
    nxt(); op(1, 3, 0, 0, 1, 2, 0, 0, 0); resolved = 1'b1;
    expect_o(0, 0, 1, 16'h0000, 0);
    nxt(); op(1, 3, 0, 0, 1, 2, 0, 0, 0); expect_o(1, 0, 0, 16'h0000, 0);
    nxt(); resolved = 1'b1; wb(2, 0);     expect_o(0, 0, 0, 16'h0004, 0); // resolve in RUN ignored
    nxt(); lock = 1'b0; op(0, 0, 0, 0, 1, 3, 0, 0, 0); wb(9, 0);
    expect_o(0, 0, 0, 16'h0000, 0);                                    // locked: nothing moves
    nxt(); op(0, 0, 0, 0, 1, 4, 0, 0, 0); expect_o(1, 0, 0, 16'h0000, 0);
    nxt(); op(0, 0, 0, 0, 1, 4, 0, 0, 0); wb(4, 0);
    expect_o(1, 0, 0, 16'h0010, 0);                                    // inc+dec same reg
    nxt(); op(0, 0, 0, 0, 1, 4, 0, 0, 0); expect_o(1, 0, 0, 16'h0010, 0);
    nxt(); op(0, 0, 0, 0, 1, 4, 0, 0, 0); expect_o(1, 0, 0, 16'h0010, 0);
    nxt(); op(0, 0, 0, 0, 1, 4, 0, 0, 0); expect_o(0, 1, 0, 16'h0010, 0); // fourth writer stalls
    nxt(); wb(4, 0);                      expect_o(0, 0, 0, 16'h0010, 0);
    nxt(); wb(4, 0);                      expect_o(0, 0, 0, 16'h0010, 0);
    nxt(); wb(4, 0);                      expect_o(0, 0, 0, 16'h0010, 0);
    nxt(); wb(7, 0);                      expect_o(0, 0, 0, 16'h0000, 0); // underflow
    nxt(); op(0, 0, 0, 0, 1, 0, 0, 0, 0); expect_o(0, 0, 1, 16'h0000, 1); // HALT
    nxt(); rst = 1'b1;                    expect_o(0, 0, 1, 16'h0000, 1);
    nxt(); op(0, 0, 0, 0, 0, 0, 0, 0, 1); expect_o(1, 0, 0, 16'h0000, 0); // JMP after reset
    nxt(); rst = 1'b1;                    expect_o(0, 0, 1, 16'h0000, 0); // reset in BR_WAIT
    nxt(); op(0, 0, 0, 0, 1, 0, 0, 0, 0); expect_o(1, 0, 0, 16'h0000, 0);
    nxt();                                expect_o(0, 0, 0, 16'h0001, 0);
    nxt();
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-control scoreboard for the 5-stage pipeline's decode stage. It tracks in-flight writes to the 16 scalar registers and the condition code. It grants or withholds issue of the instruction currently in decode, and holds fetch while a control-transfer instruction is unresolved. Writeback-to-decode forwarding is folded into the grant decision, so an instruction whose last producer writes back this cycle issues without a bubble.

## Interface
Parameters:
- NUM_REGS, 16, scalar registers tracked (R0-R7 integer, R8-R15 FP)
- IDX_W, 4, register index width
- CNT_W, 2, per-register pending-write counter width (max 3 in flight)

Ports:
- I_CLOCK  in  1  sole clock; all state updates on rising edge
- I_RESET  in  1  synchronous, active-high reset
- I_LOCK  in  1  pipeline enable; when 0, no state changes except reset
- I_IssueValid  in  1  decode holds a real (non-stall) instruction
- I_Src1Used / I_Src2Used  in  1 each  source operand is read
- I_Src1Idx / I_Src2Idx  in  IDX_W each  source register indices
- I_DestUsed  in  1  instruction writes a scalar register
- I_DestIdx  in  IDX_W  destination index
- I_SetsCC  in  1  instruction updates the condition code
- I_UsesCC  in  1  instruction reads the condition code (conditional BR*)
- I_IsBranch  in  1  BR*, JMP, JSR or JSRR
- I_WriteBackEnable  in  1  writeback retiring a register write
- I_WriteBackRegIdx  in  IDX_W  retiring register
- I_WriteBackSetsCC  in  1  retiring instruction set the condition code
- I_BranchResolved  in  1  execute has resolved the outstanding branch
- O_IssueGrant  out  1  combinational: decode instruction advances this cycle
- O_DepStallSignal  out  1  combinational: data/CC hazard blocks issue
- O_BranchStallSignal  out  1  registered: fetch must hold (BR_WAIT or HALT)
- O_PendingMask  out  NUM_REGS  registered: bit i = counter i nonzero
- O_Error  out  1  registered, sticky: scoreboard underflow/overflow detected

## Operation
- State per register: CNT_W-bit pending counter. One CC pending counter, CNT_W wide.
- Source i is ready when unused, when cnt==0, or when cnt==1 and I_WriteBackEnable and I_WriteBackRegIdx==idx.
- CC is ready when I_UsesCC=0, when ccnt==0, or when ccnt==1 and I_WriteBackEnable and I_WriteBackSetsCC.
- Dest is OK when unused or cnt[dest] < 3.
- O_DepStallSignal = I_LOCK & I_IssueValid & state==RUN & !(src1 ready & src2 ready & CC ready & dest OK).
- O_IssueGrant = I_LOCK & I_IssueValid & state==RUN & !O_DepStallSignal.
- Counter update, when I_LOCK=1:
  - The grant with I_DestUsed increments cnt[dest].
  - Writeback decrements cnt[wbidx].
  - If both hit the same index in the same cycle, the net change is 0.
  - The same rule applies to ccnt with I_SetsCC / I_WriteBackSetsCC.
- A writeback to a counter at 0, or an increment of a counter at 3, sets O_Error. The counter does not change.
- FSM:
  - RUN: a grant with I_IsBranch moves to BR_WAIT.
  - BR_WAIT: no grants. I_BranchResolved moves back to RUN.
  - Any O_Error set moves to HALT from either state.
  - HALT: no grants. Only I_RESET exits.
- I_BranchResolved is ignored in RUN and HALT.
- Writebacks continue to retire in BR_WAIT and HALT.

## Timing
- Reset: all counters 0, ccnt 0, state RUN. O_PendingMask=0, O_Error=0, O_BranchStallSignal=0.
- Reset has priority over I_LOCK and every other input, including mid-BR_WAIT.
- Grant is zero-latency (same cycle as inputs). Counter effects are visible in the next cycle.
- Branch granted in cycle N:
  - O_BranchStallSignal=1 from N+1.
  - Earliest resolve is N+1; the next grant can occur at N+2.
- I_LOCK=0 freezes all state, including a writeback presented that cycle. Upstream guarantees writeback is not dropped while locked.

## Structure
- Shared package: IDX_W, NUM_REGS, CNT_W, and the FSM state enum {RUN, BR_WAIT, HALT}. This lets fetch and decode reuse the encodings.
- Natural sub-module: hazard_counter, one saturating up/down counter with underflow/overflow flags. Instantiate it NUM_REGS+1 times (registers plus CC).

## Test plan
- Reset, then issue ADD R1←R2,R3 with no pending writes:
  - Grant=1 at once.
  - Next cycle O_PendingMask=0x0002.
- Issue writer of R1, then a reader of R1 while cnt[R1]=1:
  - DepStall=1, grant=0.
  - In the cycle writeback of R1 arrives, the reader is granted (bypass).
  - Mask bit 1 clears.
- Issue BRZ, then a CC-setting instruction, then another conditional branch:
  - With ccnt=1, the branch stalls.
  - It is granted in the cycle I_WriteBackSetsCC=1.
- Grant JMP at cycle 10:
  - O_BranchStallSignal=1 at cycle 11, grants blocked.
  - I_BranchResolved at 13 gives a grant at 14.
  - A resolve pulse while in RUN has no effect.
- Issue a writer of R4 and a writeback of R4 in the same cycle with cnt=1: cnt stays 1.
- Three writers of R4, then a fourth: the fourth stalls with DepStall=1.
- Writeback of R7 with cnt=0:
  - O_Error=1, state HALT, grant stuck at 0.
  - Synchronous I_RESET clears all.
